// File: rtl/mprj_io_cfg_pkg.sv
// Shared constants and types for the user-project pad configuration loader.
//   CFG_BITS       bits per pad in the serial frame
//   OEB_BIT / INP_DIS_BIT / DM_LSB   field offsets inside one pad's slice
//   OEB_RESET / DM_RESET             pad values held while in reset
//   state_t        loader FSM states

`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

package mprj_io_cfg_pkg;

   localparam int CFG_BITS    = 5;
   localparam int DM_BITS     = 3;
   localparam int OEB_BIT     = 0;
   localparam int INP_DIS_BIT = 1;
   localparam int DM_LSB      = 2;

   localparam logic [DM_BITS-1:0] DM_RESET  = 3'b001;
   localparam logic               OEB_RESET = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GUARD = 2'd2,
      APPLY = 2'd3
   } state_t;

endpackage

// File: rtl/mprj_io_cfg_shifter.sv
// Serial frame capture for the pad configuration loader.
// Ports:
//   clock, resetn   system clock, async active-low reset
//   shift_en        accept data this cycle
//   data            serial bit, enters bit 0 (shift left)
//   clear           zero the bit counter at the end of this cycle
//   frame_next      shift register content including this cycle's bit
//   frame_ok        post-increment count equals exactly one frame
//
// frame_next/frame_ok are the post-shift view so that a load strobe arriving
// together with the last bit sees the completed frame.

module mprj_io_cfg_shifter #(
   parameter int FRAME = 190,
   parameter int CNT_W = $clog2(FRAME + 2)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             shift_en,
   input  logic             data,
   input  logic             clear,
   output logic [FRAME-1:0] frame_next,
   output logic             frame_ok
);

   localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME);
   localparam logic [CNT_W-1:0] CNT_OVF   = CNT_W'(FRAME + 1);

   logic [FRAME-1:0] sreg;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;

   always_comb begin
      frame_next = sreg;
      count_next = count;
      if (shift_en) begin
         frame_next = {sreg[FRAME-2:0], data};
         // Saturate one past a full frame so that any overlong frame is
         // distinguishable from an exact one.
         if (count != CNT_OVF) begin
            count_next = count + 1'b1;
         end
      end
   end

   assign frame_ok = (count_next == CNT_FRAME);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sreg  <= '0;
         count <= '0;
      end else begin
         sreg  <= frame_next;
         count <= clear ? '0 : count_next;
      end
   end

endmodule

// File: rtl/mprj_io_cfg_loader.sv
// Pad configuration loader: captures a serial frame from housekeeping, checks
// its length and commits it to the pad ring with a break-before-make guard.
// Ports:
//   clock, resetn          system clock, async active-low reset
//   ser_valid, ser_data    serial bit stream (taken when ser_ready)
//   ser_load               commit strobe
//   ser_ready              loader can accept bits / loads
//   busy                   commit in progress
//   load_done              pulse: new configuration is on the outputs
//   load_err               pulse: load rejected for wrong frame length
//   oeb, inp_dis, dm       registered pad controls
//
// state | meaning
// IDLE  | no bits collected since last load
// SHIFT | collecting bits of a frame
// GUARD | all oeb forced high, waiting out the guard interval
// APPLY | new configuration on the outputs, load_done high

module mprj_io_cfg_loader
   import mprj_io_cfg_pkg::*;
#(
   parameter int TOTAL_PADS   = `MPRJ_IO_PADS,
   parameter int GUARD_CYCLES = 2
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      ser_valid,
   input  logic                      ser_data,
   input  logic                      ser_load,
   output logic                      ser_ready,
   output logic                      busy,
   output logic                      load_done,
   output logic                      load_err,
   output logic [TOTAL_PADS-1:0]     oeb,
   output logic [TOTAL_PADS-1:0]     inp_dis,
   output logic [3*TOTAL_PADS-1:0]   dm
);

   localparam int FRAME   = TOTAL_PADS * CFG_BITS;
   localparam int GUARD_N = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
   localparam int GCNT_W  = (GUARD_N > 1) ? $clog2(GUARD_N) : 1;

   localparam logic [GCNT_W-1:0] GCNT_LOAD = GCNT_W'(GUARD_N - 1);

   state_t state;
   state_t state_next;

   logic                    shift_en;
   logic                    load_req;
   logic                    load_ok;
   logic                    frame_ok;
   logic [FRAME-1:0]        frame_next;
   logic [FRAME-1:0]        shadow;
   logic [GCNT_W-1:0]       guard_cnt;
   logic                    guard_tc;
   logic [TOTAL_PADS-1:0]   shadow_oeb;
   logic [TOTAL_PADS-1:0]   shadow_inp;
   logic [3*TOTAL_PADS-1:0] shadow_dm;

   assign shift_en = ser_valid && ser_ready;
   assign load_req = ser_load && ser_ready;
   assign load_ok  = load_req && frame_ok;
   assign guard_tc = (guard_cnt == '0);

   mprj_io_cfg_shifter #(
      .FRAME (FRAME)
   ) u_shifter (
      .clock      (clock),
      .resetn     (resetn),
      .shift_en   (shift_en),
      .data       (ser_data),
      .clear      (load_req),
      .frame_next (frame_next),
      .frame_ok   (frame_ok)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, SHIFT: begin
            if (load_req) begin
               state_next = frame_ok ? GUARD : IDLE;
            end else if (shift_en) begin
               state_next = SHIFT;
            end
         end
         GUARD: begin
            if (guard_tc) begin
               state_next = APPLY;
            end
         end
         APPLY:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ser_ready = 1'b0;
      busy      = 1'b0;
      load_done = 1'b0;
      case (state)
         IDLE, SHIFT: ser_ready = 1'b1;
         GUARD:       busy      = 1'b1;
         APPLY: begin
            busy      = 1'b1;
            load_done = 1'b1;
         end
         default: ser_ready = 1'b0;
      endcase
   end

   always_comb begin
      shadow_oeb = '0;
      shadow_inp = '0;
      shadow_dm  = '0;
      for (int i = 0; i < TOTAL_PADS; i++) begin
         shadow_oeb[i]          = shadow[CFG_BITS*i + OEB_BIT];
         shadow_inp[i]          = shadow[CFG_BITS*i + INP_DIS_BIT];
         shadow_dm[DM_BITS*i +: DM_BITS] = shadow[CFG_BITS*i + DM_LSB +: DM_BITS];
      end
   end

   // Guard timer: down-counter loaded on entry to GUARD, terminal count at 0.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         guard_cnt <= '0;
      end else if (load_ok) begin
         guard_cnt <= GCNT_LOAD;
      end else if (state == GUARD && !guard_tc) begin
         guard_cnt <= guard_cnt - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         shadow   <= '0;
         load_err <= 1'b0;
      end else begin
         load_err <= load_req && !frame_ok;
         if (load_ok) begin
            shadow <= frame_next;
         end
      end
   end

   // Outputs break first (oeb forced high on commit) and only take the new
   // configuration as the guard interval expires.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         oeb     <= {TOTAL_PADS{OEB_RESET}};
         inp_dis <= '0;
         dm      <= {TOTAL_PADS{DM_RESET}};
      end else if (load_ok) begin
         oeb     <= '1;
      end else if (state == GUARD && guard_tc) begin
         oeb     <= shadow_oeb;
         inp_dis <= shadow_inp;
         dm      <= shadow_dm;
      end
   end

endmodule
